ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline latch, directly downstream of the ID/EX register fed by the decoder.
//  Consumes aluop/alusel/reg1/reg2/wd/wreg, computes logic and shift results.
//  Drives same-cycle forwarding back to the decoder (ex_*) and registered results to MEM (mem_*).
//  Has an optional iterative shifter that stalls the pipeline through a stall-request handshake.
// PARAMETERS
//  DATA_W      32  datapath width; reg1_i/reg2_i/result width
//  RADDR_W     5   register address width
//  ALUOP_W     8   aluop width (AluOpBus)
//  ALUSEL_W    3   alusel width (AluSelBus)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         synchronous reset, active-high
//  aluop_i      in   ALUOP_W   operation code from ID/EX (EXE_*_OP in defines.v)
//  alusel_i     in   ALUSEL_W  result class: EXE_RES_NOP/LOGIC/SHIFT
//  reg1_i       in   DATA_W    operand 1; for shifts, shamt = reg1_i[4:0]
//  reg2_i       in   DATA_W    operand 2; for shifts, value being shifted
//  wd_i         in   RADDR_W   destination register
//  wreg_i       in   1         destination write enable
//  stall_i      in   1         downstream freeze: hold EX/MEM latch and FSM
//  ex_wdata_o   out  DATA_W    combinational result (forwarding to ID)
//  ex_wd_o      out  RADDR_W   combinational = wd_i
//  ex_wreg_o    out  1         combinational = wreg_i & ~stallreq_o
//  mem_wdata_o  out  DATA_W    registered result to MEM
//  mem_wd_o     out  RADDR_W   registered destination
//  mem_wreg_o   out  1         registered write enable
//  stallreq_o   out  1         request upstream stall; inputs must be held stable while high
// BEHAVIOUR
//  Clocking: one clock domain (clk). Reset is synchronous and active-high (rst).
//  Reset: mem_wdata_o=0, mem_wd_o=0, mem_wreg_o=0; FSM=IDLE; shift counter=0; stallreq_o=0.
//  Logic ops (alusel=LOGIC):
//   OR_OP  -> r1|r2; AND_OP -> r1&r2; XOR_OP -> r1^r2; NOR_OP -> ~(r1|r2).
//  Shift ops (alusel=SHIFT), sh=reg1_i[4:0]:
//   SLL_OP -> r2<<sh; SRL_OP -> r2>>sh (zero fill); SRA_OP -> arithmetic right shift, sign fill from r2[31].
//  Unknown aluop within a class, or alusel=NOP: ex_wdata_o=0. wreg/wd still pass through.
//  Latency: 1 cycle. At a rising edge with stall_i=0 and stallreq_o=0, mem_* <= ex_*.
//  stall_i=1: mem_* and all internal state hold their values; stall_i has priority over FSM advance.
//  stallreq_o=1 and stall_i=0: mem_* <= bubble (wdata=0, wd=0, wreg=0).
//  Without EX_SERIAL_SHIFT_EN: stallreq_o is tied to 0; the shifter is a single-cycle barrel shifter.
// CONFIGURATION
//  `EX_SERIAL_SHIFT_EN defined: the shifter is iterative, 1 bit per cycle, using a two-state FSM (IDLE, SHIFT).
//   IDLE, shift op, sh<=1:
//    - Single-cycle result; stallreq_o=0.
//   IDLE, shift op, sh>=2:
//    - stallreq_o=1 (combinational).
//    - acc <= r2 shifted by 1; cnt <= sh-1; next state SHIFT.
//   SHIFT:
//    - While cnt>1: stallreq_o=1; acc shifts 1 bit per cycle; cnt decrements.
//    - When cnt==1: ex_wdata_o = acc shifted by 1; stallreq_o=0.
//    - That edge latches the result into mem_* and returns the FSM to IDLE.
//   Shift by n takes n cycles total, with n-1 stall cycles.
//   ex_wreg_o=0 whenever stallreq_o=1.
//   rst during SHIFT: FSM -> IDLE, cnt=0, acc=0; the partial result is discarded.
//   Logic ops are never delayed.
//  `EX_SERIAL_SHIFT_EN undefined: FSM, acc and cnt are absent; all shifts complete in one cycle.
// TESTING
//  1. OR_OP, r1=0x0000FF00, r2=0x00F0F0F0, wd=5, wreg=1
//     -> ex_wdata_o=0x00F0FFF0 same cycle.
//     -> Next edge: mem_wdata_o=0x00F0FFF0, mem_wd_o=5, mem_wreg_o=1.
//  2. NOR_OP r1=0, r2=0 -> 0xFFFFFFFF.
//     alusel=NOP, r1=r2=0xFFFFFFFF -> ex_wdata_o=0.
//  3. SRA_OP sh=4, r2=0x80000000 -> 0xF8000000.
//     SRL_OP sh=4, same r2 -> 0x08000000.
//     SLL_OP sh=31, r2=1 -> 0x80000000.
//  4. Latch 0x1234, then stall_i=1 for 2 cycles with new inputs
//     -> mem_wdata_o stays 0x1234; new value appears 1 edge after stall_i drops.
//  5. rst=1 for one edge while mem_wreg_o=1 -> all mem_* = 0 after that edge.
//  6. (EX_SERIAL_SHIFT_EN) SLL_OP sh=8, r2=1, held stable:
//     -> stallreq_o=1 for 7 cycles, with mem_wreg_o=0 bubbles.
//     -> 8th edge: mem_wdata_o=0x100.
//     -> rst asserted at cycle 3: FSM idle, stallreq_o=0 after that edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM latch: logic and shift results, forwarding outputs and the registered MEM hand-off.
// Define EX_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit-per-cycle shifter that requests upstream stalls.
module ex_stage #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [RADDR_W-1:0]  wd_i,
    input  logic                wreg_i,
    input  logic                stall_i,
    output logic [DATA_W-1:0]   ex_wdata_o,
    output logic [RADDR_W-1:0]  ex_wd_o,
    output logic                ex_wreg_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [RADDR_W-1:0]  mem_wd_o,
    output logic                mem_wreg_o,
    output logic                stallreq_o
);

    localparam logic [ALUOP_W-1:0]  EXE_AND_OP = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0]  EXE_OR_OP  = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0]  EXE_XOR_OP = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0]  EXE_NOR_OP = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0]  EXE_SLL_OP = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0]  EXE_SRL_OP = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0]  EXE_SRA_OP = 8'b0000_0011;

    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;

    logic [4:0]        sh;
    logic              is_shift_op;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] ex_wdata;
    logic              stallreq;
    logic              unused_hi;

    logic [DATA_W-1:0]  mem_wdata_q;
    logic [RADDR_W-1:0] mem_wd_q;
    logic               mem_wreg_q;

    assign sh          = reg1_i[4:0];
    assign unused_hi   = ^reg1_i[DATA_W-1:5];
    assign is_shift_op = (aluop_i == EXE_SLL_OP) || (aluop_i == EXE_SRL_OP) ||
                         (aluop_i == EXE_SRA_OP);

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

`ifdef EX_SERIAL_SHIFT_EN
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [4:0]        cnt_q;
    logic              start_shift;

    function automatic logic [DATA_W-1:0] shift1(input logic [ALUOP_W-1:0] op,
                                                 input logic [DATA_W-1:0]  v);
        case (op)
            EXE_SLL_OP: shift1 = {v[DATA_W-2:0], 1'b0};
            EXE_SRL_OP: shift1 = {1'b0, v[DATA_W-1:1]};
            EXE_SRA_OP: shift1 = {v[DATA_W-1], v[DATA_W-1:1]};
            default:    shift1 = v;
        endcase
    endfunction

    assign start_shift = (alusel_i == EXE_RES_SHIFT) && is_shift_op && (sh >= 5'd2);

    // The shift FSM owns the result until the last step; inputs are held stable meanwhile.
    always_comb begin
        ex_wdata = '0;
        stallreq = 1'b0;
        if (state_q == SHIFT) begin
            if (cnt_q > 5'd1) stallreq = 1'b1;
            else              ex_wdata = shift1(aluop_i, acc_q);
        end else if (alusel_i == EXE_RES_LOGIC) begin
            ex_wdata = logic_res;
        end else if ((alusel_i == EXE_RES_SHIFT) && is_shift_op) begin
            if (start_shift)       stallreq = 1'b1;
            else if (sh == 5'd1)   ex_wdata = shift1(aluop_i, reg2_i);
            else                   ex_wdata = reg2_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (!stall_i) begin
            case (state_q)
                IDLE: begin
                    if (start_shift) begin
                        acc_q   <= shift1(aluop_i, reg2_i);
                        cnt_q   <= sh - 5'd1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q > 5'd1) begin
                        acc_q <= shift1(aluop_i, acc_q);
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    always_comb begin
        ex_wdata = '0;
        stallreq = 1'b0;
        if (alusel_i == EXE_RES_LOGIC) begin
            ex_wdata = logic_res;
        end else if (alusel_i == EXE_RES_SHIFT) begin
            case (aluop_i)
                EXE_SLL_OP: ex_wdata = reg2_i << sh;
                EXE_SRL_OP: ex_wdata = reg2_i >> sh;
                EXE_SRA_OP: ex_wdata = $unsigned($signed(reg2_i) >>> sh);
                default:    ex_wdata = '0;
            endcase
        end
    end
`endif

    // EX/MEM latch: downstream freeze wins, a pending shift inserts bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wdata_q <= '0;
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
        end else if (!stall_i) begin
            if (stallreq) begin
                mem_wdata_q <= '0;
                mem_wd_q    <= '0;
                mem_wreg_q  <= 1'b0;
            end else begin
                mem_wdata_q <= ex_wdata;
                mem_wd_q    <= wd_i;
                mem_wreg_q  <= wreg_i;
            end
        end
    end

    assign ex_wdata_o  = ex_wdata;
    assign ex_wd_o     = wd_i;
    assign ex_wreg_o   = wreg_i & ~stallreq;
    assign stallreq_o  = stallreq;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wd_o    = mem_wd_q;
    assign mem_wreg_o  = mem_wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, stall/reset sequences and randomized ops against an arithmetic model.
// Covers the EX_SERIAL_SHIFT_EN build as well when that macro is defined.
module tb_ex_stage;

    localparam logic [7:0] OP_AND = 8'b0010_0100;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;
    localparam logic [7:0] OP_XOR = 8'b0010_0110;
    localparam logic [7:0] OP_NOR = 8'b0010_0111;
    localparam logic [7:0] OP_SLL = 8'b0111_1100;
    localparam logic [7:0] OP_SRL = 8'b0000_0010;
    localparam logic [7:0] OP_SRA = 8'b0000_0011;
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

`ifdef EX_SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg, stall;
    logic [31:0] ex_wdata, mem_wdata;
    logic [4:0]  ex_wd, mem_wd;
    logic        ex_wreg, mem_wreg, stallreq;

    int nt = 0;
    int nf = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .stall_i(stall),
        .ex_wdata_o(ex_wdata), .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg),
        .mem_wdata_o(mem_wdata), .mem_wd_o(mem_wd), .mem_wreg_o(mem_wreg),
        .stallreq_o(stallreq)
    );

    typedef struct {
        string      name;
        logic [7:0] op;
        logic [2:0] sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0] wd;
        logic       wreg;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift by sh means multiply/divide by 2**sh; arithmetic right shift
    // of a negative value is the complement of the shifted complement.
    function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] r1, input logic [31:0] r2);
        logic [63:0] p;
        logic [63:0] prod;
        int s;
        s = int'(r1 % 32);
        p = 64'd1;
        for (int i = 0; i < s; i++) p = p * 2;
        model = 32'd0;
        if (sel == SEL_LOGIC) begin
            if (op == OP_OR)  model = r1 | r2;
            if (op == OP_AND) model = r1 & r2;
            if (op == OP_XOR) model = r1 ^ r2;
            if (op == OP_NOR) model = ~(r1 | r2);
        end else if (sel == SEL_SHIFT) begin
            prod = {32'd0, r2} * p;
            if (op == OP_SLL) model = prod[31:0];
            if (op == OP_SRL) model = 32'({32'd0, r2} / p);
            if (op == OP_SRA) model = r2[31] ? ~32'({32'd0, ~r2} / p) : 32'({32'd0, r2} / p);
        end
    endfunction

    function automatic int stall_cycles(input logic [7:0] op, input logic [2:0] sel,
                                        input logic [31:0] r1);
        int s;
        s = int'(r1 % 32);
        stall_cycles = 0;
        if (SERIAL && sel == SEL_SHIFT && (op == OP_SLL || op == OP_SRL || op == OP_SRA) && s >= 2)
            stall_cycles = s - 1;
    endfunction

    task automatic run_vec(input string nm, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] d,
                           input logic w, input logic [31:0] exp);
        int ns;
        aluop = op; alusel = sel; reg1 = r1; reg2 = r2; wd = d; wreg = w; stall = 1'b0;
        #1;
        ns = stall_cycles(op, sel, r1);
        for (int k = 0; k < ns; k++) begin
            chk({nm, "_stallreq"}, 32'(stallreq), 32'd1);
            chk({nm, "_ex_wreg_gated"}, 32'(ex_wreg), 32'd0);
            tick();
            chk({nm, "_bubble_wreg"}, 32'(mem_wreg), 32'd0);
        end
        chk({nm, "_nostall"}, 32'(stallreq), 32'd0);
        chk({nm, "_ex_wdata"}, ex_wdata, exp);
        chk({nm, "_ex_wd"}, 32'(ex_wd), 32'(d));
        chk({nm, "_ex_wreg"}, 32'(ex_wreg), 32'(w));
        tick();
        chk({nm, "_mem_wdata"}, mem_wdata, exp);
        chk({nm, "_mem_wd"}, 32'(mem_wd), 32'(d));
        chk({nm, "_mem_wreg"}, 32'(mem_wreg), 32'(w));
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] ops[8];
        logic [2:0] sels[4];
        logic [7:0] rop;
        logic [2:0] rsel;
        logic [31:0] r1, r2;

        vecs.push_back('{"or_basic",  OP_OR,  SEL_LOGIC, 32'h0000FF00, 32'h00F0F0F0, 5'd5,  1'b1, 32'h00F0FFF0});
        vecs.push_back('{"nor_zero",  OP_NOR, SEL_LOGIC, 32'h0,        32'h0,        5'd1,  1'b1, 32'hFFFFFFFF});
        vecs.push_back('{"nop_class", OP_OR,  SEL_NOP,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 32'h0});
        vecs.push_back('{"and_basic", OP_AND, SEL_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9,  1'b0, 32'hF000F000});
        vecs.push_back('{"xor_basic", OP_XOR, SEL_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 5'd31, 1'b1, 32'h55555555});
        vecs.push_back('{"bad_logic", 8'h00,  SEL_LOGIC, 32'h12345678, 32'h9ABCDEF0, 5'd2,  1'b1, 32'h0});
        vecs.push_back('{"sra_neg4",  OP_SRA, SEL_SHIFT, 32'd4,        32'h80000000, 5'd3,  1'b1, 32'hF8000000});
        vecs.push_back('{"srl_4",     OP_SRL, SEL_SHIFT, 32'd4,        32'h80000000, 5'd3,  1'b1, 32'h08000000});
        vecs.push_back('{"sll_31",    OP_SLL, SEL_SHIFT, 32'd31,       32'h1,        5'd4,  1'b1, 32'h80000000});
        vecs.push_back('{"sll_0",     OP_SLL, SEL_SHIFT, 32'hFFFFFFE0, 32'hCAFEBABE, 5'd6,  1'b1, 32'hCAFEBABE});
        vecs.push_back('{"sra_pos1",  OP_SRA, SEL_SHIFT, 32'd1,        32'h7FFFFFFE, 5'd8,  1'b1, 32'h3FFFFFFF});
        vecs.push_back('{"bad_shift", OP_OR,  SEL_SHIFT, 32'd3,        32'hFFFFFFFF, 5'd10, 1'b1, 32'h0});

        rst = 1'b1; aluop = '0; alusel = '0; reg1 = '0; reg2 = '0; wd = '0; wreg = 1'b0; stall = 1'b0;
        tick(); tick();
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wd", 32'(mem_wd), 32'd0);
        chk("rst_mem_wreg", 32'(mem_wreg), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2,
                    vecs[i].wd, vecs[i].wreg, vecs[i].exp);

        // Downstream freeze holds the latch, then releases one edge later.
        run_vec("latch_1234", OP_OR, SEL_LOGIC, 32'h1234, 32'h0, 5'd12, 1'b1, 32'h1234);
        stall = 1'b1; reg1 = 32'h5678; wd = 5'd13;
        tick();
        chk("stall1_mem_wdata", mem_wdata, 32'h1234);
        chk("stall1_mem_wd", 32'(mem_wd), 32'd12);
        tick();
        chk("stall2_mem_wdata", mem_wdata, 32'h1234);
        stall = 1'b0;
        #1;
        chk("unstall_pre_edge", mem_wdata, 32'h1234);
        tick();
        chk("unstall_mem_wdata", mem_wdata, 32'h5678);
        chk("unstall_mem_wd", 32'(mem_wd), 32'd13);

        chk("pre_rst_mem_wreg", 32'(mem_wreg), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_mem_wdata", mem_wdata, 32'd0);
        chk("rst2_mem_wd", 32'(mem_wd), 32'd0);
        chk("rst2_mem_wreg", 32'(mem_wreg), 32'd0);

`ifdef EX_SERIAL_SHIFT_EN
        // Serial shift by 8: seven stall cycles with bubbles, result on the 8th edge.
        run_vec("ser_sll8", OP_SLL, SEL_SHIFT, 32'd8, 32'd1, 5'd3, 1'b1, 32'h100);
        // Reset mid-shift discards the partial result.
        aluop = OP_SLL; alusel = SEL_SHIFT; reg1 = 32'd8; reg2 = 32'd1; wd = 5'd3; wreg = 1'b1;
        tick(); tick(); tick();
        chk("ser_mid_stallreq", 32'(stallreq), 32'd1);
        rst = 1'b1; alusel = SEL_NOP;
        tick();
        rst = 1'b0;
        chk("ser_rst_stallreq", 32'(stallreq), 32'd0);
        chk("ser_rst_mem_wreg", 32'(mem_wreg), 32'd0);
        run_vec("ser_after_rst_sll1", OP_SLL, SEL_SHIFT, 32'd1, 32'h40000001, 5'd2, 1'b1, 32'h80000002);
        run_vec("ser_after_rst_srl3", OP_SRL, SEL_SHIFT, 32'd3, 32'h00000080, 5'd2, 1'b1, 32'h10);
`endif

        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, 8'h00};
        sels = '{SEL_NOP, SEL_LOGIC, SEL_SHIFT, 3'b111};
        for (int n = 0; n < 150; n++) begin
            rop  = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) rop = 8'($urandom);
            rsel = sels[$urandom_range(0, 3)];
            if (rsel == 3'b111 || $urandom_range(0, 1) == 1) rsel = (rop == OP_SLL || rop == OP_SRL || rop == OP_SRA) ? SEL_SHIFT : rsel;
            r1 = $urandom;
            r2 = $urandom;
            if ($urandom_range(0, 3) == 0) r2[31] = 1'b1;
            run_vec($sformatf("rnd%0d", n), rop, rsel, r1, r2, 5'($urandom), 1'($urandom),
                    model(rop, rsel, r1, r2));
        end

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
